// File: rtl/key_pio_pkg.sv
// Shared constants and helpers for the key input PIO: register addresses,
// edge-selection codes and a constant-evaluable ceiling log2.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_PRESS   = 0;
    localparam int EDGE_RELEASE = 1;
    localparam int EDGE_BOTH    = 2;

    // Smallest r with 2**r >= value; clog2(N+1) gives the bits needed to hold N.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key bit: 2-flop synchroniser, stable-time debounce counter and
// debounced state, with single-cycle press/release pulses on each change.
module key_debounce
    import key_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1250000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             settle;

    assign differ = (sync_p1 != state);
    // Counter tops out at CNT_LAST and is cleared on the same edge, so it never wraps.
    assign settle = differ && (cnt == CNT_LAST);

    // Pulses come out the cycle before state flips, so EDGECAP sets on the same edge as DATA.
    assign press_pulse   = settle && (state == IDLE_LEVEL);
    assign release_pulse = settle && (state != IDLE_LEVEL);

    // Stage p0/p1: synchroniser; then debounce counter and state
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= IDLE_LEVEL;
            sync_p1 <= IDLE_LEVEL;
            state   <= IDLE_LEVEL;
            cnt     <= '0;
        end else begin
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
            if (!differ) begin
                cnt <= '0;
            end else if (settle) begin
                state <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/key_pio_in.sv
// Avalon-MM key/switch input PIO: debounced DATA, IRQMASK, write-1-to-clear
// EDGECAP and a registered level interrupt.
module key_pio_in
    import key_pio_pkg::*;
#(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 1250000,
    parameter logic IDLE_LEVEL      = 1'b1,
    parameter int   EDGE_TYPE       = EDGE_PRESS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] keys_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    logic [WIDTH-1:0] key_state;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] release_ev;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, avs_writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debounce (
            .clk           (clk),
            .rst           (rst),
            .key_in        (keys_in[i]),
            .state         (key_state[i]),
            .press_pulse   (press[i]),
            .release_pulse (release_ev[i])
        );
    end

    always_comb begin
        pulse = '0;
        case (EDGE_TYPE)
            EDGE_RELEASE: pulse = release_ev;
            EDGE_BOTH:    pulse = press | release_ev;
            default:      pulse = press;
        endcase
    end

    assign edge_clr = (avs_write && (avs_address == ADDR_EDGECAP)) ?
                      avs_writedata[WIDTH-1:0] : '0;

    always_comb begin
        read_mux = '0;
        case (avs_address)
            ADDR_DATA:    read_mux[WIDTH-1:0] = key_state;
            ADDR_IRQMASK: read_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: read_mux[WIDTH-1:0] = edge_cap;
            default:      read_mux = '0;
        endcase
    end

    // Register stage: all state sampled from pre-write values, so a same-cycle
    // read sees the old contents and a capture pulse beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask     <= '0;
            edge_cap     <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (avs_write && (avs_address == ADDR_IRQMASK)) begin
                irq_mask <= avs_writedata[WIDTH-1:0];
            end
            edge_cap <= (edge_cap & ~edge_clr) | pulse;
            irq      <= |(edge_cap & irq_mask);
            if (avs_read) begin
                avs_readdata <= read_mux;
            end
        end
    end

endmodule
